io_port_bridge: RTL and testbench

//  Buffers the processor's 8-bit I/O ports against external devices. Bytes written via

---
 rtl/io_port_bridge_pkg.sv | 19 +
 rtl/io_port_bridge_fifo.sv | 80 ++++++++
 rtl/io_port_bridge.sv | 112 +++++++++++
 tb/tb_io_port_bridge.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_bridge_pkg.sv
// Shared constants and types for the datapath I/O port bridge.
// The datapath imports the same byte width so both sides stay consistent.
package io_port_bridge_pkg;

  localparam int IO_DATA_W    = 8;
  localparam int IO_OUT_DEPTH = 4;
  localparam int IO_IN_DEPTH  = 4;

  typedef struct packed {
    logic out_overflow;
    logic in_underflow;
  } err_flags_t;

  // A new error event in the same cycle as a clear keeps the flag set.
  function automatic logic sticky_next(input logic flag, input logic clr, input logic evt);
    return (flag & ~clr) | evt;
  endfunction

endpackage

// File: rtl/io_port_bridge_fifo.sv
// Synchronous show-ahead FIFO used for both bridge directions, plus its
// invariant checker (simulation-only assertions, no logic).
module bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);

endmodule

module bridge_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   push,
  input logic                   pop,
  input logic                   full,
  input logic                   empty,
  input logic [$clog2(DEPTH):0] count
);

  localparam logic [$clog2(DEPTH):0] CNT_MAX = ($clog2(DEPTH)+1)'(DEPTH);

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_MAX);
  a_no_overrun:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  a_no_underrun: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_full_flag:   assert property (@(posedge clk) disable iff (!rst_n) full == (count == CNT_MAX));
  a_empty_flag:  assert property (@(posedge clk) disable iff (!rst_n) empty == (count == '0));

endmodule

// File: rtl/io_port_bridge.sv
// Buffers the datapath's 8-bit IN/OUT ports against external valid/ready links,
// with sticky overflow/underflow flags for strobes the FIFOs could not honour.
module io_port_bridge
  import io_port_bridge_pkg::*;
#(
  parameter int DATA_W    = IO_DATA_W,
  parameter int OUT_DEPTH = IO_OUT_DEPTH,
  parameter int IN_DEPTH  = IO_IN_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_strobe,
  input  logic [DATA_W-1:0] output_port,
  input  logic              read_strobe,
  output logic [DATA_W-1:0] input_port,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              clear_flags,
  output logic              out_overflow,
  output logic              in_underflow
);

  logic                         out_push;
  logic                         out_pop;
  logic                         out_full;
  logic                         out_empty;
  logic [$clog2(OUT_DEPTH):0]   out_count;
  logic                         in_push;
  logic                         in_pop;
  logic                         in_full;
  logic                         in_empty;
  logic [$clog2(IN_DEPTH):0]    in_count;
  logic [DATA_W-1:0]            in_head;
  logic                         ovf_evt;
  logic                         unf_evt;
  err_flags_t                   flags;

  // A same-cycle drain frees the slot, so a write to a full FIFO is still taken.
  assign out_pop  = ~out_empty & tx_ready;
  assign out_push = write_strobe & (~out_full | out_pop);
  assign ovf_evt  = write_strobe & out_full & ~out_pop;

  assign in_push  = rx_valid & ~in_full;
  assign in_pop   = read_strobe & ~in_empty;
  assign unf_evt  = read_strobe & in_empty;

  bridge_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_push),
    .pop   (out_pop),
    .din   (output_port),
    .head  (tx_data),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  bridge_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_push),
    .pop   (in_pop),
    .din   (rx_data),
    .head  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  bridge_fifo_chk #(.DEPTH(OUT_DEPTH)) u_out_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_push),
    .pop   (out_pop),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  bridge_fifo_chk #(.DEPTH(IN_DEPTH)) u_in_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_push),
    .pop   (in_pop),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  assign tx_valid   = ~out_empty;
  assign rx_ready   = ~in_full;
  assign input_port = in_empty ? '0 : in_head;

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else begin
      flags.out_overflow <= sticky_next(flags.out_overflow, clear_flags, ovf_evt);
      flags.in_underflow <= sticky_next(flags.in_underflow, clear_flags, unf_evt);
    end
  end

  assign out_overflow = flags.out_overflow;
  assign in_underflow = flags.in_underflow;

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_io_port_bridge;

  localparam int OD = 4;
  localparam int ID = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_strobe = 1'b0;
  logic [7:0] output_port = 8'h00;
  logic       read_strobe = 1'b0;
  logic [7:0] input_port;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       clear_flags = 1'b0;
  logic       out_overflow;
  logic       in_underflow;

  io_port_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_strobe (write_strobe),
    .output_port  (output_port),
    .read_strobe  (read_strobe),
    .input_port   (input_port),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .clear_flags  (clear_flags),
    .out_overflow (out_overflow),
    .in_underflow (in_underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] oq[$];
  logic [7:0] iq[$];
  logic [7:0] tx_log[$];
  logic [7:0] rd_log[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, log handshakes, then advance the model by one edge.
  task automatic model_cycle();
    bit o_pop, o_acc, i_push, i_pop, ovf_e, unf_e;
    if (!rst_n) begin
      oq.delete();
      iq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      chk("tx_valid", 32'(tx_valid), 32'(oq.size() != 0));
      if (oq.size() != 0) chk("tx_data", 32'(tx_data), 32'(oq[0]));
      chk("rx_ready", 32'(rx_ready), 32'(iq.size() < ID));
      chk("input_port", 32'(input_port), (iq.size() != 0) ? 32'(iq[0]) : 32'd0);
      chk("out_overflow", 32'(out_overflow), 32'(m_ovf));
      chk("in_underflow", 32'(in_underflow), 32'(m_unf));
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (read_strobe) rd_log.push_back(input_port);

      o_pop  = (oq.size() != 0) && tx_ready;
      o_acc  = write_strobe && ((oq.size() < OD) || o_pop);
      ovf_e  = write_strobe && !o_acc;
      i_push = rx_valid && (iq.size() < ID);
      i_pop  = read_strobe && (iq.size() != 0);
      unf_e  = read_strobe && (iq.size() == 0);
      if (o_pop) void'(oq.pop_front());
      if (o_acc) oq.push_back(output_port);
      if (i_pop) void'(iq.pop_front());
      if (i_push) iq.push_back(rx_data);
      m_ovf = (m_ovf && !clear_flags) || ovf_e;
      m_unf = (m_unf && !clear_flags) || unf_e;
    end
  endtask

  always @(negedge clk) model_cycle();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    rx_valid     = 1'b0;
    clear_flags  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp2 [4];
    exp2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // 1: reset mid-traffic
    write_strobe = 1'b1; output_port = 8'hC1; tick();
    output_port = 8'hC2; tick();
    idle();
    chk("t1_valid_before", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("t1_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t1_rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("t1_rst_input_port", 32'(input_port), 32'd0);
    chk("t1_rst_flags", 32'({out_overflow, in_underflow}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("t1_post_tx_valid", 32'(tx_valid), 32'd0);
    chk("t1_post_rx_ready", 32'(rx_ready), 32'd1);

    // 2: burst into full OUT FIFO, overflow, ordered drain
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write_strobe = 1'b1; output_port = exp2[i]; tick();
    end
    output_port = 8'hA5; tick();
    idle();
    chk("t2_overflow", 32'(out_overflow), 32'd1);
    tx_log.delete();
    tx_ready = 1'b1;
    repeat (5) tick();
    tx_ready = 1'b0;
    chk("t2_drain_count", 32'(tx_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < tx_log.size()) chk("t2_drain_data", 32'(tx_log[i]), 32'(exp2[i]));
    end
    chk("t2_empty_after", 32'(tx_valid), 32'd0);

    // 3: write to full OUT FIFO with a same-cycle pop
    clear_flags = 1'b1; tick(); idle();
    for (int i = 0; i < 4; i++) begin
      write_strobe = 1'b1; output_port = 8'hB1 + 8'(i); tick();
    end
    tx_log.delete();
    output_port = 8'h55; tx_ready = 1'b1; tick();
    idle();
    chk("t3_no_overflow", 32'(out_overflow), 32'd0);
    repeat (5) tick();
    tx_ready = 1'b0;
    chk("t3_drain_count", 32'(tx_log.size()), 32'd5);
    if (tx_log.size() != 0) chk("t3_last_byte", 32'(tx_log[tx_log.size()-1]), 32'h55);

    // 4: IN path and underflow
    rx_valid = 1'b1; rx_data = 8'h10; tick();
    rx_data = 8'h20; tick();
    idle();
    rd_log.delete();
    read_strobe = 1'b1;
    repeat (3) tick();
    idle();
    chk("t4_read_count", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      chk("t4_read0", 32'(rd_log[0]), 32'h10);
      chk("t4_read1", 32'(rd_log[1]), 32'h20);
      chk("t4_read2", 32'(rd_log[2]), 32'h00);
    end
    chk("t4_underflow", 32'(in_underflow), 32'd1);

    // 5: IN backpressure
    clear_flags = 1'b1; tick(); idle();
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'h30 + 8'(i); tick();
    end
    idle();
    chk("t5_rx_ready_full", 32'(rx_ready), 32'd0);
    read_strobe = 1'b1; tick(); idle();
    chk("t5_rx_ready_freed", 32'(rx_ready), 32'd1);
    chk("t5_next_head", 32'(input_port), 32'h31);
    read_strobe = 1'b1; repeat (3) tick(); idle();

    // 6: interleaved traffic across pointer wrap, then clear vs new underflow
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      write_strobe = (i % 2 == 0);
      read_strobe  = (i % 2 == 1);
      output_port  = 8'($urandom);
      rx_valid     = 1'b1;
      rx_data      = 8'($urandom);
      tick();
    end
    idle();
    read_strobe = 1'b1; repeat (6) tick(); idle();
    read_strobe = 1'b1; clear_flags = 1'b1; tick(); idle();
    chk("t6_clear_vs_underflow", 32'(in_underflow), 32'd1);
    clear_flags = 1'b1; tick(); idle();
    chk("t6_cleared", 32'(in_underflow), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      write_strobe = ($urandom_range(2) == 0);
      read_strobe  = ($urandom_range(2) == 0);
      output_port  = 8'($urandom);
      tx_ready     = ($urandom_range(1) == 0);
      rx_valid     = ($urandom_range(1) == 0);
      rx_data      = 8'($urandom);
      clear_flags  = ($urandom_range(15) == 0);
      tick();
    end
    idle();
    tx_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
